ex_wb_regfile: RTL and testbench

- Downstream consumer of the ID/EX pipeline register outputs in the 8-bit core.
- Performs the execute operation (ADD or MOV), latches the result in an EX/WB stage register, and writes the result back into an 8-entry register file.
- Provides the decode stage with register-file read ports, write-back bypass and EX-operand forwarding, closing the loop back to the ID/EX inputs.

---
 rtl/ex_wb_regfile_if.sv | 37 +++
 rtl/ex_wb_regfile.sv | 114 +++++++++++
 tb/tb_ex_wb_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_wb_regfile_if.sv
// EX-stage operand/control bundle, decode read ports and EX/WB status of the 8-bit core.
// master = ID/EX + decode side, slave = ex_wb_regfile.
interface ex_wb_regfile_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] ex_rsdata_in;
  logic [DATA_W-1:0] ex_rddata_in;
  logic [ADDR_W-1:0] ex_rs_in;
  logic [ADDR_W-1:0] ex_rd_in;
  logic              ex_write_mux_in;
  logic              ex_regwrite_in;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_rs_rdata;
  logic [DATA_W-1:0] id_rd_rdata;
  logic              wb_valid_out;
  logic [ADDR_W-1:0] wb_rd_out;
  logic [DATA_W-1:0] wb_data_out;
  logic              carry_out;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output ex_rsdata_in, ex_rddata_in, ex_rs_in, ex_rd_in, ex_write_mux_in, ex_regwrite_in,
    output id_rs_addr, id_rd_addr,
    input  id_rs_rdata, id_rd_rdata, wb_valid_out, wb_rd_out, wb_data_out, carry_out,
    input  retired_count
  );

  modport slave (
    input  ex_rsdata_in, ex_rddata_in, ex_rs_in, ex_rd_in, ex_write_mux_in, ex_regwrite_in,
    input  id_rs_addr, id_rd_addr,
    output id_rs_rdata, id_rd_rdata, wb_valid_out, wb_rd_out, wb_data_out, carry_out,
    output retired_count
  );
endinterface

// File: rtl/ex_wb_regfile.sv
// Execute (ADD/MOV) with EX/WB latch, 8-entry register file, bypassed read ports and forwarding.
// Optional ZERO_REG_EN: r0 hardwired to zero (writes dropped but counted, no bypass/forwarding).
module ex_wb_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  ex_wb_regfile_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              carry_q;
  logic              carry_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              fwd_s;
  logic              fwd_d;
  logic [DATA_W-1:0] op_s;
  logic [DATA_W-1:0] op_d;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result_d;
  logic              wr_en;
  logic [DATA_W-1:0] rs_rdata;
  logic [DATA_W-1:0] rd_rdata;

  // Operand forwarding from EX/WB, then execute.
  always_comb begin
    fwd_s    = wb_valid_q && (wb_rd_q == bus.ex_rs_in) && !(ZERO_EN && (bus.ex_rs_in == '0));
    fwd_d    = wb_valid_q && (wb_rd_q == bus.ex_rd_in) && !(ZERO_EN && (bus.ex_rd_in == '0));
    op_s     = fwd_s ? wb_data_q : bus.ex_rsdata_in;
    op_d     = fwd_d ? wb_data_q : bus.ex_rddata_in;
    sum      = {1'b0, op_s} + {1'b0, op_d};
    result_d = bus.ex_write_mux_in ? op_s : sum[DATA_W-1:0];
  end

  // Carry tracks only ADDs that write; retired counter saturates.
  always_comb begin
    carry_d = carry_q;
    if (bus.ex_regwrite_in && !bus.ex_write_mux_in) begin
      carry_d = sum[DATA_W];
    end
    cnt_d = cnt_q;
    if (wb_valid_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    wr_en = wb_valid_q && !(ZERO_EN && (wb_rd_q == '0));
  end

  // Read ports with write-through bypass of the pending EX/WB value.
  always_comb begin
    rs_rdata = regs_q[bus.id_rs_addr];
    if (ZERO_EN && (bus.id_rs_addr == '0)) begin
      rs_rdata = '0;
    end else if (wb_valid_q && (wb_rd_q == bus.id_rs_addr)) begin
      rs_rdata = wb_data_q;
    end
    rd_rdata = regs_q[bus.id_rd_addr];
    if (ZERO_EN && (bus.id_rd_addr == '0)) begin
      rd_rdata = '0;
    end else if (wb_valid_q && (wb_rd_q == bus.id_rd_addr)) begin
      rd_rdata = wb_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= bus.ex_regwrite_in;
      wb_rd_q    <= bus.ex_rd_in;
      wb_data_q  <= result_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
    end
  end

  // Register file: written one edge after the EX/WB latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign bus.id_rs_rdata   = rs_rdata;
  assign bus.id_rd_rdata   = rd_rdata;
  assign bus.wb_valid_out  = wb_valid_q;
  assign bus.wb_rd_out     = wb_rd_q;
  assign bus.wb_data_out   = wb_data_q;
  assign bus.carry_out     = carry_q;
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_ex_wb_regfile.sv
// Bench for ex_wb_regfile: directed cases plus random traffic against an architectural model.
// Honours ZERO_REG_EN when the build defines it.
module tb_ex_wb_regfile;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 16;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ex_wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  ex_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Architectural state: register file, one pending write, carry flag, retired count.
  int m_reg [8];
  bit m_pv;
  int m_prd;
  int m_pdata;
  bit m_carry;
  int m_cnt;

  int cur_mux, cur_we, cur_rs, cur_rd, cur_rsd, cur_rdd, cur_ia, cur_ib;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_pv = 0; m_prd = 0; m_pdata = 0; m_carry = 0; m_cnt = 0;
  endfunction

  function automatic int operand(input int a, input int d);
    if (m_pv && m_prd == a && !(ZR && a == 0)) return m_pdata;
    return d;
  endfunction

  function automatic int exp_read(input int a);
    if (ZR && a == 0) return 0;
    if (m_pv && m_prd == a) return m_pdata;
    return m_reg[a];
  endfunction

  task automatic drive(input int mux, input int we, input int rs, input int rd,
                       input int rsd, input int rdd, input int ia, input int ib);
    cur_mux = mux; cur_we = we; cur_rs = rs; cur_rd = rd;
    cur_rsd = rsd; cur_rdd = rdd; cur_ia = ia; cur_ib = ib;
    bus.ex_write_mux_in = 1'(mux);
    bus.ex_regwrite_in  = 1'(we);
    bus.ex_rs_in        = ADDR_W'(rs);
    bus.ex_rd_in        = ADDR_W'(rd);
    bus.ex_rsdata_in    = DATA_W'(rsd);
    bus.ex_rddata_in    = DATA_W'(rdd);
    bus.id_rs_addr      = ADDR_W'(ia);
    bus.id_rd_addr      = ADDR_W'(ib);
  endtask

  task automatic check_all();
    check("wb_valid", int'(bus.wb_valid_out), int'(m_pv));
    check("wb_rd", int'(bus.wb_rd_out), m_prd);
    check("wb_data", int'(bus.wb_data_out), m_pdata);
    check("carry", int'(bus.carry_out), int'(m_carry));
    check("retired", int'(bus.retired_count), m_cnt);
    check("rs_rdata", int'(bus.id_rs_rdata), exp_read(cur_ia));
    check("rd_rdata", int'(bus.id_rd_rdata), exp_read(cur_ib));
  endtask

  // One clock: evaluate the instruction on the model, advance, compare.
  task automatic step();
    int os, od, res, s;
    os = operand(cur_rs, cur_rsd);
    od = operand(cur_rd, cur_rdd);
    s  = os + od;
    res = (cur_mux != 0) ? os : (s % 256);
    @(posedge clock);
    #1;
    if (m_pv) begin
      if (!(ZR && m_prd == 0)) m_reg[m_prd] = m_pdata;
      if (m_cnt < 65535) m_cnt++;
    end
    if (cur_we != 0 && cur_mux == 0) m_carry = (s > 255);
    m_pv = (cur_we != 0); m_prd = cur_rd; m_pdata = res;
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    drive(0, 1, 5, 6, 8'h3C, 8'hC4, 1, 2);
    @(posedge clock);
    #1;
    check("rst_valid", int'(bus.wb_valid_out), 0);
    check("rst_data", int'(bus.wb_data_out), 0);
    check("rst_rd", int'(bus.wb_rd_out), 0);
    check("rst_carry", int'(bus.carry_out), 0);
    check("rst_count", int'(bus.retired_count), 0);
    reset = 1'b1;

    for (int a = 0; a < 8; a++) begin
      drive(1, 0, 0, 0, 0, 0, a, 7 - a);
      step();
      check("rst_reg", int'(bus.id_rs_rdata), 0);
    end

    // MOV r3 <- 0xA5
    drive(1, 1, 0, 3, 8'hA5, 0, 3, 3);
    step();
    check("mov_valid", int'(bus.wb_valid_out), 1);
    check("mov_rd", int'(bus.wb_rd_out), 3);
    check("mov_data", int'(bus.wb_data_out), 8'hA5);
    drive(1, 0, 0, 0, 0, 0, 3, 0);
    step();
    check("mov_rf", int'(bus.id_rs_rdata), 8'hA5);
    check("mov_cnt", int'(bus.retired_count), 1);

    // ADD with carry, then MOV keeps carry
    drive(0, 1, 5, 2, 8'hF0, 8'h20, 0, 0);
    step();
    check("add_data", int'(bus.wb_data_out), 8'h10);
    check("add_carry", int'(bus.carry_out), 1);
    drive(1, 1, 7, 6, 8'h11, 0, 2, 6);
    step();
    check("mov_carry", int'(bus.carry_out), 1);

    // Forwarding of r1 into the next ADD
    drive(0, 1, 4, 1, 8'h02, 8'h03, 1, 2);
    step();
    check("fwd_prod", int'(bus.wb_data_out), 8'h05);
    drive(0, 1, 1, 5, 8'h00, 8'h03, 1, 5);
    step();
    check("fwd_use", int'(bus.wb_data_out), 8'h08);

    // Bypass of pending r4
    drive(1, 1, 2, 4, 8'h77, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 3, 4);
    #1;
    check("bypass", int'(bus.id_rd_rdata), 8'h77);
    check("bypass_rs", int'(bus.id_rs_rdata), 8'hA5);
    step();

`ifdef ZERO_REG_EN
    drive(1, 1, 3, 0, 8'h55, 0, 0, 0);
    step();
    check("zr_read_pend", int'(bus.id_rs_rdata), 0);
    drive(0, 1, 0, 3, 8'h01, 8'h02, 0, 0);
    step();
    check("zr_nofwd", int'(bus.wb_data_out), 8'h03);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("zr_read", int'(bus.id_rs_rdata), 0);
`endif

    // Reset mid-operation discards the pending write
    drive(1, 1, 0, 5, 8'h99, 0, 5, 5);
    step();
    drive(0, 1, 5, 5, 8'h01, 8'h01, 5, 5);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("mrst_valid", int'(bus.wb_valid_out), 0);
    check("mrst_data", int'(bus.wb_data_out), 0);
    check("mrst_count", int'(bus.retired_count), 0);
    check("mrst_r5", int'(bus.id_rs_rdata), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    check("mrst_hold", int'(bus.wb_valid_out), 0);
    for (int a = 0; a < 8; a++) begin
      drive(1, 0, 0, 0, 0, 0, a, a);
      step();
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(int'($urandom % 2), int'(($urandom % 4) != 0), int'($urandom % 8),
            int'($urandom % 8), int'($urandom % 256), int'($urandom % 256),
            int'($urandom % 8), int'($urandom % 8));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
